// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared combinational ALU.
// Grants alternate on ties, one operation is in flight at a time, and mul
// occupies the ALU for MUL_LAT cycles before its result is captured.
//
// state | meaning
// IDLE  | no operation in flight; grant offered to a requester
// EXEC  | latched operation driven to the ALU; counter paces mul latency
// DONE  | result held on the response port until the consumer accepts
module alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req0_valid_i,
  input  logic [2:0]       req0_ctrl_i,
  input  logic [WIDTH-1:0] req0_data1_i,
  input  logic [WIDTH-1:0] req0_data2_i,
  output logic             req0_ready_o,
  input  logic             req1_valid_i,
  input  logic [2:0]       req1_ctrl_i,
  input  logic [WIDTH-1:0] req1_data1_i,
  input  logic [WIDTH-1:0] req1_data2_i,
  output logic             req1_ready_o,
  output logic [2:0]       alu_ctrl_o,
  output logic [WIDTH-1:0] alu_data1_o,
  output logic [WIDTH-1:0] alu_data2_o,
  input  logic [WIDTH-1:0] alu_result_i,
  output logic             rsp_valid_o,
  output logic             rsp_id_o,
  output logic [WIDTH-1:0] rsp_data_o,
  input  logic             rsp_ready_i
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [2:0] CTRL_ADD = 3'b010;
  localparam logic [2:0] CTRL_MUL = 3'b011;
  localparam logic [3:0] MUL_CNT  = 4'(MUL_LAT - 1);

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [2:0]       ctrl_q, ctrl_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [WIDTH-1:0] data2_q, data2_d;
  logic             id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             grant0, grant1;

  // Arbitration: only in IDLE; on a tie the requester not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (req0_valid_i && req1_valid_i) begin
        if (last_grant_q) grant0 = 1'b1;
        else              grant1 = 1'b1;
      end else if (req0_valid_i) begin
        grant0 = 1'b1;
      end else if (req1_valid_i) begin
        grant1 = 1'b1;
      end
    end
  end

  assign req0_ready_o = grant0;
  assign req1_ready_o = grant1;

  // Next-state logic: capture on handshake, pace EXEC, hold result in DONE.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    ctrl_d       = ctrl_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          ctrl_d       = grant1 ? req1_ctrl_i  : req0_ctrl_i;
          data1_d      = grant1 ? req1_data1_i : req0_data1_i;
          data2_d      = grant1 ? req1_data2_i : req0_data2_i;
          id_d         = grant1;
          last_grant_d = grant1;
          cnt_d        = (ctrl_d == CTRL_MUL) ? MUL_CNT : 4'd0;
          state_d      = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          rsp_data_d  = alu_result_i;
          rsp_id_d    = id_q;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      ctrl_q       <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      ctrl_q       <= ctrl_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  // ALU drive: a harmless add of zeros while idle, latched operation otherwise.
  always_comb begin
    alu_ctrl_o  = CTRL_ADD;
    alu_data1_o = '0;
    alu_data2_o = '0;
    if (state_q != IDLE) begin
      alu_ctrl_o  = ctrl_q;
      alu_data1_o = data1_q;
      alu_data2_o = data2_q;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus random traffic, checked
// against a transaction-level model (pending op, due cycle, expected result).
module tb_alu_arbiter;

  localparam int WIDTH   = 32;
  localparam int MUL_LAT = 3;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             req0_valid_i, req1_valid_i;
  logic [2:0]       req0_ctrl_i, req1_ctrl_i;
  logic [WIDTH-1:0] req0_data1_i, req0_data2_i, req1_data1_i, req1_data2_i;
  logic             req0_ready_o, req1_ready_o;
  logic [2:0]       alu_ctrl_o;
  logic [WIDTH-1:0] alu_data1_o, alu_data2_o, alu_result_i;
  logic             rsp_valid_o, rsp_id_o, rsp_ready_i;
  logic [WIDTH-1:0] rsp_data_o;

  int n_checks = 0;
  int n_errors = 0;

  // model state
  int               cyc = 0;
  bit               m_pend = 0;
  int               m_due = 0;
  bit               m_last = 1;
  bit               m_id = 0;
  logic [2:0]       m_ctrl = 3'b010;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_data = '0;

  alu_arbiter #(.WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_ctrl_i(req0_ctrl_i),
    .req0_data1_i(req0_data1_i), .req0_data2_i(req0_data2_i),
    .req0_ready_o(req0_ready_o),
    .req1_valid_i(req1_valid_i), .req1_ctrl_i(req1_ctrl_i),
    .req1_data1_i(req1_data1_i), .req1_data2_i(req1_data2_i),
    .req1_ready_o(req1_ready_o),
    .alu_ctrl_o(alu_ctrl_o), .alu_data1_o(alu_data1_o), .alu_data2_o(alu_data2_o),
    .alu_result_i(alu_result_i),
    .rsp_valid_o(rsp_valid_o), .rsp_id_o(rsp_id_o), .rsp_data_o(rsp_data_o),
    .rsp_ready_i(rsp_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // The shared ALU lives outside the arbiter; unknown codes give a distinct mix.
  function automatic logic [WIDTH-1:0] alu_fn(input logic [2:0] c,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b011:  return a * b;
      default: return a ^ b ^ 32'h5A5A_C3C3;
    endcase
  endfunction

  assign alu_result_i = alu_fn(alu_ctrl_o, alu_data1_o, alu_data2_o);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got 0x%0h, want 0x%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs just after negedge, check, advance model at posedge.
  task automatic step(input logic v0, input logic [2:0] c0,
                      input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                      input logic v1, input logic [2:0] c1,
                      input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                      input logic rr);
    bit e_r0, e_r1, due_now;
    req0_valid_i = v0; req0_ctrl_i = c0; req0_data1_i = a0; req0_data2_i = b0;
    req1_valid_i = v1; req1_ctrl_i = c1; req1_data1_i = a1; req1_data2_i = b1;
    rsp_ready_i  = rr;
    #1;
    e_r0 = 0;
    e_r1 = 0;
    if (!m_pend) begin
      if (v0 && v1) begin
        if (m_last) e_r0 = 1; else e_r1 = 1;
      end else if (v0) e_r0 = 1;
      else if (v1)     e_r1 = 1;
    end
    due_now = m_pend && (cyc >= m_due);
    check("req0_ready", 64'(req0_ready_o), 64'(e_r0));
    check("req1_ready", 64'(req1_ready_o), 64'(e_r1));
    check("rsp_valid", 64'(rsp_valid_o), 64'(due_now));
    if (due_now) begin
      check("rsp_id", 64'(rsp_id_o), 64'(m_id));
      check("rsp_data", 64'(rsp_data_o), 64'(m_data));
    end
    if (!m_pend) begin
      check("idle_alu_ctrl", 64'(alu_ctrl_o), 64'(3'b010));
      check("idle_alu_d1", 64'(alu_data1_o), 64'd0);
      check("idle_alu_d2", 64'(alu_data2_o), 64'd0);
    end else if (!due_now) begin
      check("exec_alu_ctrl", 64'(alu_ctrl_o), 64'(m_ctrl));
      check("exec_alu_d1", 64'(alu_data1_o), 64'(m_a));
      check("exec_alu_d2", 64'(alu_data2_o), 64'(m_b));
    end
    @(posedge clk_i);
    cyc++;
    if (e_r0 || e_r1) begin
      m_pend = 1;
      m_id   = e_r1;
      m_last = e_r1;
      m_ctrl = e_r1 ? c1 : c0;
      m_a    = e_r1 ? a1 : a0;
      m_b    = e_r1 ? b1 : b0;
      m_data = alu_fn(m_ctrl, m_a, m_b);
      m_due  = cyc + ((m_ctrl == 3'b011) ? MUL_LAT : 1);
    end else if (due_now && rr) begin
      m_pend = 0;
    end
    @(negedge clk_i);
  endtask

  task automatic idle_steps(input int n, input logic rr);
    for (int i = 0; i < n; i++) step(0, 3'b0, '0, '0, 0, 3'b0, '0, '0, rr);
  endtask

  // Asynchronous reset pulse in the middle of a cycle, released before the next edge.
  task automatic pulse_reset();
    req0_valid_i = 0;
    req1_valid_i = 0;
    rsp_ready_i  = 0;
    #2 rst_i = 1;
    #1;
    check("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("rst_rsp_id", 64'(rsp_id_o), 64'd0);
    check("rst_rsp_data", 64'(rsp_data_o), 64'd0);
    check("rst_alu_ctrl", 64'(alu_ctrl_o), 64'(3'b010));
    check("rst_ready0", 64'(req0_ready_o), 64'd0);
    #1 rst_i = 0;
    m_pend = 0;
    m_last = 1;
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
  endtask

  initial begin
    logic [2:0] ops [8];
    ops = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b011, 3'b111, 3'b100, 3'b101};
    rst_i = 1;
    req0_valid_i = 0; req0_ctrl_i = '0; req0_data1_i = '0; req0_data2_i = '0;
    req1_valid_i = 0; req1_ctrl_i = '0; req1_data1_i = '0; req1_data2_i = '0;
    rsp_ready_i  = 0;
    @(negedge clk_i);
    check("init_rsp_valid", 64'(rsp_valid_o), 64'd0);
    check("init_rsp_data", 64'(rsp_data_o), 64'd0);
    check("init_alu_ctrl", 64'(alu_ctrl_o), 64'(3'b010));
    rst_i = 0;

    // add 5+7 from req0
    step(1, 3'b010, 32'd5, 32'd7, 0, 3'b0, '0, '0, 1);
    idle_steps(3, 1);

    // contention: grants alternate starting with req0 after reset
    pulse_reset();
    for (int i = 0; i < 9; i++)
      step(1, 3'b110, 32'd9, 32'd4, 1, 3'b001, 32'hF0, 32'h0F, 1);
    idle_steps(3, 1);

    // mul 6*7 from req1
    step(0, 3'b0, '0, '0, 1, 3'b011, 32'd6, 32'd7, 1);
    idle_steps(5, 1);

    // backpressure with req0 waiting
    step(1, 3'b010, 32'd100, 32'd23, 0, 3'b0, '0, '0, 0);
    for (int i = 0; i < 6; i++) step(1, 3'b000, 32'hFF00, 32'h0FF0, 0, 3'b0, '0, '0, 0);
    step(1, 3'b000, 32'hFF00, 32'h0FF0, 0, 3'b0, '0, '0, 1);
    step(1, 3'b000, 32'hFF00, 32'h0FF0, 0, 3'b0, '0, '0, 1);
    idle_steps(3, 1);

    // reset in the middle of a mul; tie afterwards goes to req0
    step(0, 3'b0, '0, '0, 1, 3'b011, 32'd3, 32'd3, 1);
    idle_steps(1, 1);
    pulse_reset();
    idle_steps(4, 1);
    step(1, 3'b001, 32'h1, 32'h2, 1, 3'b001, 32'h4, 32'h8, 1);
    idle_steps(3, 1);

    // undefined control code passes through with short latency
    step(1, 3'b111, 32'h1234_5678, 32'h0F0F_0F0F, 0, 3'b0, '0, '0, 1);
    idle_steps(3, 1);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), ops[$urandom_range(0, 7)], $urandom, $urandom,
           1'($urandom_range(0, 1)), ops[$urandom_range(0, 7)], $urandom, $urandom,
           1'($urandom_range(0, 2) != 0));
    idle_steps(MUL_LAT + 3, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
